// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request ports and memory bus of the two-port memory arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_done;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_done;
    logic [DW-1:0] p1_rdata;

    logic          cpu_stall;
    logic [1:0]    gnt;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_done, p0_rdata, p1_done, p1_rdata,
        output cpu_stall, gnt,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and memory side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_done, p0_rdata, p1_done, p1_rdata,
        input  cpu_stall, gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one unified memory between the CPU and a secondary master
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state;
    logic          last;
    logic [2:0]    cnt;
    logic [1:0]    gnt_q;
    logic          p0_done_q;
    logic          p1_done_q;
    logic [DW-1:0] p0_rdata_q;
    logic [DW-1:0] p1_rdata_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          pick_p1;

    // On a tie the port that was not served last wins; reset leaves last=1 so port 0 wins first.
    always_comb begin
        pick_p1 = bus.p1_req & (~bus.p0_req | ~last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= 3'd0;
            gnt_q       <= 2'b00;
            p0_done_q   <= 1'b0;
            p1_done_q   <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            mem_en_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.p0_req | bus.p1_req) begin
                        gnt_q       <= pick_p1 ? 2'b10 : 2'b01;
                        last        <= pick_p1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= pick_p1 ? bus.p1_we    : bus.p0_we;
                        mem_addr_q  <= pick_p1 ? bus.p1_addr  : bus.p0_addr;
                        mem_wdata_q <= pick_p1 ? bus.p1_wdata : bus.p0_wdata;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_we_q) begin
                        p0_done_q <= gnt_q[0];
                        p1_done_q <= gnt_q[1];
                        state     <= RESP;
                    end else begin
                        cnt   <= 3'(LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (gnt_q[1]) begin
                            p1_rdata_q <= bus.mem_rdata;
                        end else begin
                            p0_rdata_q <= bus.mem_rdata;
                        end
                        p0_done_q <= gnt_q[0];
                        p1_done_q <= gnt_q[1];
                        state     <= RESP;
                    end
                end
                RESP: begin
                    gnt_q <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    gnt_q <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.p0_done   = p0_done_q;
    assign bus.p1_done   = p1_done_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.gnt       = gnt_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    // Combinational so the control FSM stalls in the very cycle it raises its request.
    assign bus.cpu_stall = bus.p0_req & ~p0_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at LAT=1 and LAT=3
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if ia ();
    mem_arbiter_if ib ();

    mem_arbiter #(.AW(32), .DW(32), .LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    mem_arbiter #(.AW(32), .DW(32), .LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int c;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] pipe_a [0:3];
    logic [31:0] pipe_b [0:3];
    logic [3:0]  dones;

    assign dones = {ib.p1_done, ib.p0_done, ia.p1_done, ia.p0_done};

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is present only in cycle (mem_en cycle + LAT)
    always @(posedge clk) begin
        if (ia.mem_en && ia.mem_we) mem_a[ia.mem_addr[7:2]] <= ia.mem_wdata;
        pipe_a[0] <= (ia.mem_en && !ia.mem_we) ? mem_a[ia.mem_addr[7:2]] : 32'h0;
        if (ib.mem_en && ib.mem_we) mem_b[ib.mem_addr[7:2]] <= ib.mem_wdata;
        pipe_b[0] <= (ib.mem_en && !ib.mem_we) ? mem_b[ib.mem_addr[7:2]] : 32'h0;
        for (int i = 1; i < 4; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign ia.mem_rdata = pipe_a[0];
    assign ib.mem_rdata = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("exclusive", {28'h0, ia.gnt == 2'b11, ib.gnt == 2'b11,
                            ia.p0_done & ia.p1_done, ib.p0_done & ib.p1_done}, 32'h0);
    end

    task automatic start_cycle();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic wait_done(input logic [3:0] mask, output int cc);
        bit hit;
        hit = 1'b0;
        cc = -1;
        for (int i = 0; i < 40; i++) begin
            if (!hit) begin
                @(negedge clk);
                if ((dones & mask) != 4'b0) begin
                    hit = 1'b1;
                    cc = cyc - t0;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ia.p0_req = 0; ia.p0_we = 0; ia.p0_addr = 0; ia.p0_wdata = 0;
        ia.p1_req = 0; ia.p1_we = 0; ia.p1_addr = 0; ia.p1_wdata = 0;
        ib.p0_req = 0; ib.p0_we = 0; ib.p0_addr = 0; ib.p0_wdata = 0;
        ib.p1_req = 0; ib.p1_we = 0; ib.p1_addr = 0; ib.p1_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] <= 32'h0;
            mem_b[i] <= 32'h0;
        end
        #1;
        mem_a[32] <= 32'h1234_5678; mem_b[32] <= 32'h1234_5678;
        mem_a[4]  <= 32'hCAFE_F00D; mem_b[4]  <= 32'hCAFE_F00D;

        repeat (2) @(negedge clk);
        check("rst_gnt",      {30'h0, ia.gnt}, 32'h0);
        check("rst_mem_en",   {31'h0, ia.mem_en}, 32'h0);
        check("rst_mem_we",   {31'h0, ia.mem_we}, 32'h0);
        check("rst_mem_addr", ia.mem_addr, 32'h0);
        check("rst_mem_wdat", ia.mem_wdata, 32'h0);
        check("rst_done",     {30'h0, ia.p1_done, ia.p0_done}, 32'h0);
        check("rst_rdata0",   ia.p0_rdata, 32'h0);
        check("rst_rdata1",   ia.p1_rdata, 32'h0);
        check("rst_b_en_gnt", {29'h0, ib.mem_en, ib.gnt}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Port 0 write, LAT=1 instance
        start_cycle();
        ia.p0_req = 1; ia.p0_we = 1; ia.p0_addr = 32'h40; ia.p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("w_c0_stall", {31'h0, ia.cpu_stall}, 32'h1);
        check("w_c0_en",    {31'h0, ia.mem_en}, 32'h0);
        @(negedge clk);
        check("w_c1_en_we", {30'h0, ia.mem_en, ia.mem_we}, 32'h3);
        check("w_c1_addr",  ia.mem_addr, 32'h40);
        check("w_c1_wdata", ia.mem_wdata, 32'hDEAD_BEEF);
        check("w_c1_gnt",   {30'h0, ia.gnt}, 32'h1);
        check("w_c1_stall", {31'h0, ia.cpu_stall}, 32'h1);
        @(negedge clk);
        check("w_c2_done",  {30'h0, ia.p1_done, ia.p0_done}, 32'h1);
        check("w_c2_stall", {31'h0, ia.cpu_stall}, 32'h0);
        check("w_c2_en",    {31'h0, ia.mem_en}, 32'h0);
        @(posedge clk); #1 ia.p0_req = 0; ia.p0_we = 0;
        check("w_mem", mem_a[16], 32'hDEAD_BEEF);

        // Port 1 read, LAT=1
        start_cycle();
        ia.p1_req = 1; ia.p1_we = 0; ia.p1_addr = 32'h80;
        wait_done(4'b0010, c);
        check("r1_cycle", c, 3);
        check("r1_rdata", ia.p1_rdata, 32'h1234_5678);
        check("r1_p0_rdata", ia.p0_rdata, 32'h0);
        @(posedge clk); #1 ia.p1_req = 0;

        // LAT=3: port 0 read then port 1 read
        start_cycle();
        ib.p0_req = 1; ib.p0_we = 0; ib.p0_addr = 32'h10;
        wait_done(4'b0100, c);
        check("r3p0_cycle", c, 5);
        check("r3p0_rdata", ib.p0_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1 ib.p0_req = 0;
        start_cycle();
        ib.p1_req = 1; ib.p1_we = 0; ib.p1_addr = 32'h80;
        wait_done(4'b1000, c);
        check("r3p1_cycle", c, 5);
        check("r3p1_rdata", ib.p1_rdata, 32'h1234_5678);
        check("r3p1_p0_kept", ib.p0_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1 ib.p1_req = 0;

        // Continuous contention from reset, LAT=1: p0,p1,p0,p1 every 4 cycles
        @(posedge clk); #1 reset = 1'b1;
        ia.p0_req = 1; ia.p0_we = 0; ia.p0_addr = 32'h80;
        ia.p1_req = 1; ia.p1_we = 0; ia.p1_addr = 32'h10;
        @(posedge clk); #1 reset = 1'b0; t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_done(4'b0011, c);
            check("rr_cycle", c, 3 + 4 * k);
            check("rr_owner", {31'h0, ia.p1_done}, k % 2);
            if (k % 2 == 0) check("rr_rdata0", ia.p0_rdata, 32'h1234_5678);
            else            check("rr_rdata1", ia.p1_rdata, 32'hCAFE_F00D);
        end
        @(posedge clk); #1 ia.p0_req = 0; ia.p1_req = 0;

        // Port 1 back-to-back writes
        start_cycle();
        ia.p1_req = 1; ia.p1_we = 1; ia.p1_addr = 32'h0; ia.p1_wdata = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            wait_done(4'b0010, c);
            check("bb_cycle", c, 2 + 3 * i);
            check("bb_gnt", {30'h0, ia.gnt}, 32'h2);
            @(posedge clk); #1;
            if (i < 3) begin
                ia.p1_addr = 32'(4 * (i + 1)); ia.p1_wdata = 32'h1000 + 32'(i + 1);
            end else begin
                ia.p1_req = 0; ia.p1_we = 0;
            end
        end
        for (int i = 0; i < 4; i++) check("bb_mem", mem_a[i], 32'h1000 + 32'(i));

        // Reset during WAIT of a LAT=3 read; request stays held
        start_cycle();
        ib.p1_req = 1; ib.p1_we = 0; ib.p1_addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        check("rw_c1_en", {31'h0, ib.mem_en}, 32'h1);
        @(negedge clk);
        check("rw_c2_wait", {29'h0, ib.mem_en, ib.gnt}, 32'h2);
        @(negedge clk); #1 reset = 1'b1;
        #1;
        check("rw_rst_en_gnt", {29'h0, ib.mem_en, ib.gnt}, 32'h0);
        check("rw_rst_done", {31'h0, ib.p1_done}, 32'h0);
        check("rw_rst_rdata", ib.p1_rdata, 32'h0);
        @(posedge clk); #1 reset = 1'b0; t0 = cyc;
        wait_done(4'b1000, c);
        check("rw_cycle", c, 5);
        check("rw_rdata", ib.p1_rdata, 32'h1234_5678);
        @(posedge clk); #1 ib.p1_req = 0;

        // p0 write then simultaneous p0 write / p1 read with last=0
        start_cycle();
        ia.p0_req = 1; ia.p0_we = 1; ia.p0_addr = 32'h20; ia.p0_wdata = 32'h5555_AAAA;
        wait_done(4'b0001, c);
        check("tie_pre_cycle", c, 2);
        @(posedge clk); #1 ia.p0_req = 0;
        start_cycle();
        ia.p0_req = 1; ia.p0_we = 1; ia.p0_addr = 32'h24; ia.p0_wdata = 32'h0BAD_F00D;
        ia.p1_req = 1; ia.p1_we = 0; ia.p1_addr = 32'h80;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("tie_stall",  {31'h0, ia.cpu_stall}, (k < 6) ? 32'h1 : 32'h0);
            check("tie_p1done", {31'h0, ia.p1_done}, (k == 3) ? 32'h1 : 32'h0);
            check("tie_p0done", {31'h0, ia.p0_done}, (k == 6) ? 32'h1 : 32'h0);
            check("tie_en",     {31'h0, ia.mem_en}, (k == 1 || k == 5) ? 32'h1 : 32'h0);
            if (k == 1) check("tie_p1_addr", ia.mem_addr, 32'h80);
            if (k == 3) begin
                check("tie_p1_rdata", ia.p1_rdata, 32'h1234_5678);
                @(posedge clk); #1 ia.p1_req = 0;
            end
            if (k == 5) check("tie_p0_addr_we", {ia.mem_addr[30:0], ia.mem_we}, {31'h24, 1'b1});
        end
        @(posedge clk); #1 ia.p0_req = 0; ia.p0_we = 0;
        check("tie_mem", mem_a[9], 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
